quad_counter: RTL and testbench
===============================

Name: quad_counter

Overview:
- Parametrised successor to the single-pulse encoder counter.
- Decodes a raw two-phase quadrature encoder (A/B) into a WIDTH-bit signed-agnostic up/down position count.
- Runtime-selectable x1/x2/x4 decode, input synchronisers, synchronous clear/load, wrap flag and a per-update valid strobe.
- Sits between the encoder pins and the HBA peripheral register file; one instance per motor channel.

Parameters:
- WIDTH, 16, count width in bits (2..32).
- FWD, 1, direction sense: 1 = A-leads-B counts up; 0 = A-leads-B counts down.
- SYNC_STAGES, 2, synchroniser flops on each of A and B (2..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets all state).
- en  in  1  valid-strobe enable; deasserted by the register file during reads.
- enc_a  in  1  raw encoder phase A, asynchronous.
- enc_b  in  1  raw encoder phase B, asynchronous.
- mode  in  2  decode mode: 00 = x1, 01 = x2, 10/11 = x4.
- clear  in  1  synchronous count clear.
- load  in  1  synchronous count load.
- load_value  in  WIDTH  value written on load.
- count  out  WIDTH  current position.
- dir  out  1  direction of last counted step: 1 = up, 0 = down.
- valid  out  1  one-cycle strobe: count changed and en was high.
- wrap  out  1  one-cycle strobe: count wrapped, max->0 up or 0->max down.

Behaviour:
- Reset (reset==0, async):
  - count=0, dir=0, valid=0, wrap=0.
  - All synchroniser and prev-state flops = 0.
- Synchroniser: enc_a/enc_b pass SYNC_STAGES flops to give cur={a,b}; prev={a,b} is registered one cycle later.
- Step decode on (prev,cur), for FWD=1:
  - Up sequence: 00->10->11->01->00. Down is the reverse.
  - x4: every legal single-bit transition is a step.
  - x2: A edges only. Up: 00->10, 11->01. Down: 10->00, 01->11.
  - x1: A rising only. Up: 00->10. Down: 01->11.
  - FWD=0 swaps up/down.
  - prev==cur: no step.
  - Both bits changed (illegal transition): no step, count unchanged.
- Latency: an enc_a/enc_b edge updates count SYNC_STAGES+1 clk edges later.
- Count update priority, highest first:
  1. clear: count<=0; valid and wrap low.
  2. load: count<=load_value; valid and wrap low.
  3. step: count<=count±1, modulo 2^WIDTH. dir<=1 for up, 0 for down.
  - A step arriving in the same cycle as clear or load is discarded.
- valid: 1 for exactly one cycle after a counted step when en==1 that cycle; otherwise 0. count still updates when en==0.
- wrap: 1 for one cycle when the step takes count from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down). Independent of en.
- dir holds its value between steps; clear and load do not change dir.
- mode changes take effect on the next decoded transition. No state flush is needed.
- Reset deasserted while enc inputs are 11: the synchroniser passes 00->...->11. The resulting prev/cur pair 00->11 is illegal and does not count.
- reset asserted mid-count: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro QUAD_COUNTER_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err pulses for one cycle on each illegal two-bit transition.
  - Adds output err_sticky (1 bit, reset 0): sets on any err and clears only on clear.
- Not defined: neither port exists; illegal transitions are silently ignored.
- Count behaviour is identical in both builds.

Test Plan:
- x4, FWD=1, en=1: drive 4 full up cycles (16 transitions) -> count=16, 16 valid pulses, dir=1. Then 16 reverse transitions -> count=0, dir=0.
- Mode sweep: one full up cycle per mode -> x1 count +1, x2 count +2, x4 count +4. Latency of the first update = SYNC_STAGES+1 cycles after the enc_a edge.
- Wrap, WIDTH=16: load 0xFFFF, one up step -> count=0x0000 with wrap=1 for one cycle. Then one down step -> 0xFFFF with wrap=1.
- en=0 during 3 up steps -> count advances by 3, valid stays 0. Step in the same cycle as clear -> count=0, no valid.
- Illegal transition 00->11 -> count unchanged. With QUAD_COUNTER_ERR_EN: err=1 for one cycle and err_sticky=1 until clear.
- Async reset mid-run (count=0x1234): assert reset=0 between clock edges -> count=0, valid/wrap/dir=0 before the next clk edge. Release with enc=11 -> no count.

Source files
------------

// File: rtl/quad_counter.sv
// Quadrature encoder decoder: synchronises raw A/B and decodes x1/x2/x4 steps into a WIDTH-bit up/down count.
// Optional macro QUAD_COUNTER_ERR_EN adds err/err_sticky outputs for illegal two-bit transitions.
module quad_counter #(
    parameter int WIDTH       = 16,
    parameter bit FWD         = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             valid,
    output logic             wrap
`ifdef QUAD_COUNTER_ERR_EN
    ,
    output logic             err,
    output logic             err_sticky
`endif
);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             cur;
    logic [1:0]             prev;
    logic                   fwd_step;
    logic                   rev_step;
    logic                   a_edge;
    logic                   fwd_ok;
    logic                   rev_ok;
    logic                   step_up;
    logic                   step_dn;

    // Position of an {a,b} pair along the forward sequence 00->10->11->01.
    function automatic logic [1:0] phase_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   phase_idx = 2'd0;
            2'b10:   phase_idx = 2'd1;
            2'b11:   phase_idx = 2'd2;
            default: phase_idx = 2'd3;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sync <= '0;
            b_sync <= '0;
            prev   <= 2'b00;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], enc_a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], enc_b};
            prev   <= cur;
        end
    end

    assign cur = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

    always_comb begin
        fwd_step = 1'b0;
        rev_step = 1'b0;
        fwd_ok   = 1'b0;
        rev_ok   = 1'b0;
        a_edge   = prev[1] ^ cur[1];
        // Exactly one bit changed is a legal step; both bits changed is dropped.
        if ((prev ^ cur) == 2'b01 || (prev ^ cur) == 2'b10) begin
            fwd_step = (phase_idx(cur) == phase_idx(prev) + 2'd1);
            rev_step = !fwd_step;
        end
        case (mode)
            2'b00: begin
                fwd_ok = (prev == 2'b00) && (cur == 2'b10);
                rev_ok = (prev == 2'b01) && (cur == 2'b11);
            end
            2'b01: begin
                fwd_ok = fwd_step && a_edge;
                rev_ok = rev_step && a_edge;
            end
            default: begin
                fwd_ok = fwd_step;
                rev_ok = rev_step;
            end
        endcase
        step_up = FWD ? fwd_ok : rev_ok;
        step_dn = FWD ? rev_ok : fwd_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            dir   <= 1'b0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= load_value;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (step_up) begin
            count <= count + WIDTH'(1);
            dir   <= 1'b1;
            valid <= en;
            wrap  <= (count == {WIDTH{1'b1}});
        end else if (step_dn) begin
            count <= count - WIDTH'(1);
            dir   <= 1'b0;
            valid <= en;
            wrap  <= (count == '0);
        end else begin
            valid <= 1'b0;
            wrap  <= 1'b0;
        end
    end

`ifdef QUAD_COUNTER_ERR_EN
    logic illegal;
    assign illegal = ((prev ^ cur) == 2'b11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err <= illegal;
            if (clear)
                err_sticky <= 1'b0;
            else if (illegal)
                err_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_quad_counter.sv
// Directed bench for quad_counter (WIDTH=16, FWD=1, SYNC_STAGES=2) with hand-computed expectations.
module tb_quad_counter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             en;
    logic             enc_a;
    logic             enc_b;
    logic [1:0]       mode;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             valid;
    logic             wrap;
`ifdef QUAD_COUNTER_ERR_EN
    logic             err;
    logic             err_sticky;
    int               ecnt;
`endif

    int errors;
    int checks;
    int vcnt;
    int wcnt;

    quad_counter #(.WIDTH(WIDTH), .FWD(1'b1), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .mode       (mode),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .dir        (dir),
        .valid      (valid),
        .wrap       (wrap)
`ifdef QUAD_COUNTER_ERR_EN
        ,
        .err        (err),
        .err_sticky (err_sticky)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 ns after the rising edge, outputs sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
        vcnt += int'(valid);
        wcnt += int'(wrap);
`ifdef QUAD_COUNTER_ERR_EN
        ecnt += int'(err);
`endif
    endtask

    task automatic move(input logic [1:0] ab);
        {enc_a, enc_b} = ab;
        repeat (3) tick();
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load_value = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (count !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h exp=0000", count); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", dir); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    endtask

    task automatic test_x4();
        logic [1:0] up_seq [4];
        logic [1:0] dn_seq [4];
        up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        dn_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        mode = 2'b10;
        vcnt = 0;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) move(up_seq[k]);
        checks++; if (count !== 16'd16) begin errors++; $display("FAIL x4_up_count got=%0d exp=16", count); end
        checks++; if (vcnt !== 16) begin errors++; $display("FAIL x4_up_valid got=%0d exp=16", vcnt); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL x4_up_dir got=%b exp=1", dir); end
        vcnt = 0;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++) move(dn_seq[k]);
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL x4_dn_count got=%0d exp=0", count); end
        checks++; if (vcnt !== 16) begin errors++; $display("FAIL x4_dn_valid got=%0d exp=16", vcnt); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL x4_dn_dir got=%b exp=0", dir); end
    endtask

    task automatic test_mode_sweep();
        // x1 from count 0, including latency of the first update
        mode = 2'b00;
        {enc_a, enc_b} = 2'b10;
        tick();
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL lat_edge1 got=%0d exp=0", count); end
        tick();
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL lat_edge2 got=%0d exp=0", count); end
        tick();
        checks++; if (count !== 16'd1) begin errors++; $display("FAIL lat_edge3 got=%0d exp=1", count); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b exp=1", valid); end
        move(2'b11); move(2'b01); move(2'b00);
        checks++; if (count !== 16'd1) begin errors++; $display("FAIL x1_cycle got=%0d exp=1", count); end
        mode = 2'b01;
        move(2'b10); move(2'b11); move(2'b01); move(2'b00);
        checks++; if (count !== 16'd3) begin errors++; $display("FAIL x2_cycle got=%0d exp=3", count); end
        mode = 2'b11;
        move(2'b10); move(2'b11); move(2'b01); move(2'b00);
        checks++; if (count !== 16'd7) begin errors++; $display("FAIL x4_cycle got=%0d exp=7", count); end
    endtask

    task automatic test_wrap();
        mode = 2'b10;
        do_load(16'hFFFF);
        checks++; if (count !== 16'hFFFF) begin errors++; $display("FAIL load_count got=%h exp=ffff", count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL load_valid got=%b exp=0", valid); end
        move(2'b10);
        checks++; if (count !== 16'h0000) begin errors++; $display("FAIL wrap_up_count got=%h exp=0000", count); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_up_flag got=%b exp=1", wrap); end
        tick();
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_pulse got=%b exp=0", wrap); end
        move(2'b00);
        checks++; if (count !== 16'hFFFF) begin errors++; $display("FAIL wrap_dn_count got=%h exp=ffff", count); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_dn_flag got=%b exp=1", wrap); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL wrap_dn_dir got=%b exp=0", dir); end
        tick();
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_dn_pulse got=%b exp=0", wrap); end
    endtask

    task automatic test_en_and_clear();
        en = 1'b0;
        vcnt = 0;
        wcnt = 0;
        move(2'b10); move(2'b11); move(2'b01);
        checks++; if (count !== 16'h0002) begin errors++; $display("FAIL en0_count got=%h exp=0002", count); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL en0_valid got=%0d exp=0", vcnt); end
        checks++; if (wcnt !== 1) begin errors++; $display("FAIL en0_wrap got=%0d exp=1", wcnt); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL en0_dir got=%b exp=1", dir); end
        en = 1'b1;
        vcnt = 0;
        // Down step 01->11 lands on the same edge as clear and must be discarded.
        {enc_a, enc_b} = 2'b11;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (count !== 16'h0000) begin errors++; $display("FAIL clr_count got=%h exp=0000", count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", valid); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL clr_dir got=%b exp=1", dir); end
        tick();
        tick();
        checks++; if (count !== 16'h0000) begin errors++; $display("FAIL clr_hold got=%h exp=0000", count); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL clr_vcnt got=%0d exp=0", vcnt); end
    endtask

    task automatic test_illegal();
        do_load(16'd5);
        vcnt = 0;
`ifdef QUAD_COUNTER_ERR_EN
        ecnt = 0;
`endif
        {enc_a, enc_b} = 2'b00;
        repeat (4) tick();
        checks++; if (count !== 16'd5) begin errors++; $display("FAIL illegal_count got=%0d exp=5", count); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL illegal_valid got=%0d exp=0", vcnt); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL illegal_dir got=%b exp=1", dir); end
`ifdef QUAD_COUNTER_ERR_EN
        checks++; if (ecnt !== 1) begin errors++; $display("FAIL err_pulses got=%0d exp=1", ecnt); end
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_sticky_set got=%b exp=1", err_sticky); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_sticky_clr got=%b exp=0", err_sticky); end
`endif
    endtask

    task automatic test_async_reset();
        do_load(16'h1234);
        checks++; if (count !== 16'h1234) begin errors++; $display("FAIL pre_rst_count got=%h exp=1234", count); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL pre_rst_dir got=%b exp=1", dir); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        {enc_a, enc_b} = 2'b11;
        #1;
        checks++; if (count !== 16'h0000) begin errors++; $display("FAIL arst_count got=%h exp=0000", count); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL arst_dir got=%b exp=0", dir); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", valid); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL arst_wrap got=%b exp=0", wrap); end
        @(posedge clk);
        #3;
        reset = 1'b1;
        vcnt = 0;
        repeat (6) tick();
        checks++; if (count !== 16'h0000) begin errors++; $display("FAIL rel11_count got=%h exp=0000", count); end
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL rel11_valid got=%0d exp=0", vcnt); end
        move(2'b01);
        checks++; if (count !== 16'h0001) begin errors++; $display("FAIL post_rst_step got=%h exp=0001", count); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL post_rst_dir got=%b exp=1", dir); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vcnt = 0;
        wcnt = 0;
`ifdef QUAD_COUNTER_ERR_EN
        ecnt = 0;
`endif
        reset = 1'b0;
        en = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        mode = 2'b10;
        clear = 1'b0;
        load = 1'b0;
        load_value = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        repeat (2) tick();
        test_x4();
        test_mode_sweep();
        test_wrap();
        test_en_and_clear();
        test_illegal();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
